// File: rtl/ip_log2_pkg.sv
// Shared definitions for the log2 blocks: FSM state encoding and the
// log2ceil helper used to size integer result fields.
package ip_log2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT  = 2'd1,
        FRAC = 2'd2
    } state_e;

    function automatic int unsigned log2ceil(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ip_log2_sqr.sv
// One mantissa-squaring step: squares a 1.MWID mantissa, emits the next
// log2 fraction bit and the renormalised mantissa.
module ip_log2_sqr #(
    parameter int unsigned MWID = 12
) (
    input  logic [MWID:0] i_m,
    output logic [MWID:0] o_m,
    output logic          o_bit
);

    logic [2*MWID+1:0] sq;

    // sq is in 2.2MWID format; its top bit set means sq >= 2.
    assign sq    = {{(MWID+1){1'b0}}, i_m} * {{(MWID+1){1'b0}}, i_m};
    assign o_bit = sq[2*MWID+1];
    assign o_m   = o_bit ? sq[2*MWID+1:MWID+1] : sq[2*MWID:MWID];

endmodule

// File: rtl/ip_log2frac.sv
// Multi-cycle fixed-point log2 (IWID.FBWID). Define LOG2_ROUND_EN to add a
// guard iteration with half-up rounding and saturation instead of truncation.
module ip_log2frac
    import ip_log2_pkg::*;
#(
    parameter  int unsigned IDWID = 16,
    parameter  int unsigned FBWID = 4,
    parameter  int unsigned MWID  = 12,
    localparam int unsigned IWID  = log2ceil(IDWID),
    localparam int unsigned ODWID = IWID + FBWID
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cal_str,
    input  logic [IDWID-1:0] i_val,
    output logic [ODWID-1:0] o_val,
    output logic             o_val_vld,
    output logic             o_val_upd,
    output logic             o_zero,
    output logic             o_busy
);

`ifdef LOG2_ROUND_EN
    localparam int unsigned NFR = FBWID + 1;
`else
    localparam int unsigned NFR = FBWID;
`endif
    localparam int unsigned XW   = IDWID + MWID;
    localparam int unsigned CWID = log2ceil(NFR + 1);

    state_e             state_q, state_d;
    logic [XW-1:0]      x_sh_q, x_sh_d;
    logic [IWID-1:0]    int_cnt_q, int_cnt_d;
    logic [MWID:0]      m_q, m_d;
    logic [NFR-1:0]     frac_sh_q, frac_sh_d;
    logic [CWID-1:0]    frac_cnt_q, frac_cnt_d;
    logic [ODWID-1:0]   o_val_q, o_val_d;
    logic               o_val_vld_q, o_val_vld_d;
    logic               o_val_upd_q, o_val_upd_d;
    logic               o_zero_q, o_zero_d;

    logic [IDWID-1:0]   field;
    logic [MWID:0]      sqr_m;
    logic               sqr_bit;
    logic [NFR:0]       frac_all;
    logic [NFR-1:0]     frac_nxt;
    logic [ODWID-1:0]   result;

    ip_log2_sqr #(.MWID(MWID)) u_sqr (
        .i_m   (m_q),
        .o_m   (sqr_m),
        .o_bit (sqr_bit)
    );

    assign field    = x_sh_q[XW-1:MWID];
    assign frac_all = {frac_sh_q, sqr_bit};
    assign frac_nxt = frac_all[NFR-1:0];

`ifdef LOG2_ROUND_EN
    logic [ODWID:0]   full;
    logic [ODWID+1:0] rsum;
    logic [ODWID:0]   rnd;

    // Half-up: add one at the guard position, drop the guard, saturate on carry-out.
    assign full   = {int_cnt_q, frac_nxt};
    assign rsum   = {1'b0, full} + (ODWID+2)'(1);
    assign rnd    = rsum[ODWID+1:1];
    assign result = rnd[ODWID] ? '1 : rnd[ODWID-1:0];
`else
    assign result = {int_cnt_q, frac_nxt};
`endif

    always_comb begin
        state_d     = state_q;
        x_sh_d      = x_sh_q;
        int_cnt_d   = int_cnt_q;
        m_d         = m_q;
        frac_sh_d   = frac_sh_q;
        frac_cnt_d  = frac_cnt_q;
        o_val_d     = o_val_q;
        o_val_vld_d = o_val_vld_q;
        o_val_upd_d = 1'b0;
        o_zero_d    = o_zero_q;

        if (i_cal_str) begin
            x_sh_d      = {i_val, {MWID{1'b0}}};
            int_cnt_d   = '0;
            frac_sh_d   = '0;
            frac_cnt_d  = '0;
            o_val_vld_d = 1'b0;
            state_d     = INT;
        end else begin
            case (state_q)
                INT: begin
                    if (field == '0) begin
                        o_val_d     = '0;
                        o_zero_d    = 1'b1;
                        o_val_upd_d = 1'b1;
                        o_val_vld_d = 1'b1;
                        state_d     = IDLE;
                    end else if (field == IDWID'(1)) begin
                        m_d     = x_sh_q[MWID:0];
                        state_d = FRAC;
                    end else begin
                        x_sh_d    = x_sh_q >> 1;
                        int_cnt_d = int_cnt_q + IWID'(1);
                    end
                end
                FRAC: begin
                    m_d        = sqr_m;
                    frac_sh_d  = frac_nxt;
                    frac_cnt_d = frac_cnt_q + CWID'(1);
                    if (frac_cnt_q == CWID'(NFR - 1)) begin
                        o_val_d     = result;
                        o_zero_d    = 1'b0;
                        o_val_upd_d = 1'b1;
                        o_val_vld_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_sh_q      <= '0;
            int_cnt_q   <= '0;
            m_q         <= '0;
            frac_sh_q   <= '0;
            frac_cnt_q  <= '0;
            o_val_q     <= '0;
            o_val_vld_q <= 1'b0;
            o_val_upd_q <= 1'b0;
            o_zero_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_sh_q      <= x_sh_d;
            int_cnt_q   <= int_cnt_d;
            m_q         <= m_d;
            frac_sh_q   <= frac_sh_d;
            frac_cnt_q  <= frac_cnt_d;
            o_val_q     <= o_val_d;
            o_val_vld_q <= o_val_vld_d;
            o_val_upd_q <= o_val_upd_d;
            o_zero_q    <= o_zero_d;
        end
    end

    assign o_val     = o_val_q;
    assign o_val_vld = o_val_vld_q;
    assign o_val_upd = o_val_upd_q;
    assign o_zero    = o_zero_q;
    assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ip_log2frac.sv
// Directed bench for ip_log2frac at default parameters (IDWID=16, FBWID=4,
// MWID=12); expectations follow LOG2_ROUND_EN when it is defined.
module tb_ip_log2frac;

    logic        clk;
    logic        rst_n;
    logic        i_cal_str;
    logic [15:0] i_val;
    logic [7:0]  o_val;
    logic        o_val_vld;
    logic        o_val_upd;
    logic        o_zero;
    logic        o_busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

`ifdef LOG2_ROUND_EN
    localparam int unsigned NFR = 5;
`else
    localparam int unsigned NFR = 4;
`endif

    ip_log2frac #(.IDWID(16), .FBWID(4), .MWID(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cal_str (i_cal_str),
        .i_val     (i_val),
        .o_val     (o_val),
        .o_val_vld (o_val_vld),
        .o_val_upd (o_val_upd),
        .o_zero    (o_zero),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [7:0]  exp_val;
        logic        exp_zero;
        int unsigned k;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] v);
        i_val     = v;
        i_cal_str = 1'b1;
        tick();
        i_cal_str = 1'b0;
    endtask

    // Returns edges from the start edge to the update pulse (0 on timeout).
    task automatic wait_upd(output int unsigned n, output bit vld_low_ok);
        int unsigned cnt;
        cnt        = 0;
        n          = 0;
        vld_low_ok = 1'b1;
        while (cnt < 100) begin
            tick();
            cnt++;
            if (o_val_upd) begin
                n = cnt;
                break;
            end
            if (o_val_vld) vld_low_ok = 1'b0;
        end
    endtask

    vec_t        vecs[11];
    int unsigned lat;
    int unsigned exp_lat;
    bit          vld_ok;
    int unsigned pulses;
    logic [7:0]  first_val;

    initial begin
`ifdef LOG2_ROUND_EN
        vecs[0]  = '{16'd1,     8'h00, 1'b0, 0};
        vecs[1]  = '{16'd2,     8'h10, 1'b0, 1};
        vecs[2]  = '{16'd3,     8'h19, 1'b0, 1};
        vecs[3]  = '{16'd0,     8'h00, 1'b1, 0};
        vecs[4]  = '{16'd2,     8'h10, 1'b0, 1};
        vecs[5]  = '{16'd7,     8'h2D, 1'b0, 2};
        vecs[6]  = '{16'd5,     8'h25, 1'b0, 2};
        vecs[7]  = '{16'd10,    8'h35, 1'b0, 3};
        vecs[8]  = '{16'd100,   8'h6A, 1'b0, 6};
        vecs[9]  = '{16'h8000,  8'hF0, 1'b0, 15};
        vecs[10] = '{16'hFFFF,  8'hFF, 1'b0, 15};
`else
        vecs[0]  = '{16'd1,     8'h00, 1'b0, 0};
        vecs[1]  = '{16'd2,     8'h10, 1'b0, 1};
        vecs[2]  = '{16'd3,     8'h19, 1'b0, 1};
        vecs[3]  = '{16'd0,     8'h00, 1'b1, 0};
        vecs[4]  = '{16'd2,     8'h10, 1'b0, 1};
        vecs[5]  = '{16'd7,     8'h2C, 1'b0, 2};
        vecs[6]  = '{16'd5,     8'h25, 1'b0, 2};
        vecs[7]  = '{16'd10,    8'h35, 1'b0, 3};
        vecs[8]  = '{16'd100,   8'h6A, 1'b0, 6};
        vecs[9]  = '{16'h8000,  8'hF0, 1'b0, 15};
        vecs[10] = '{16'hFFFF,  8'hFF, 1'b0, 15};
`endif

        rst_n     = 1'b0;
        i_cal_str = 1'b0;
        i_val     = '0;
        repeat (3) tick();
        chk("rst_val",  32'(o_val), 32'h0);
        chk("rst_vld",  32'(o_val_vld), 32'h0);
        chk("rst_upd",  32'(o_val_upd), 32'h0);
        chk("rst_zero", 32'(o_zero), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            exp_lat = vecs[i].exp_zero ? 1 : vecs[i].k + 1 + NFR;
            start_op(vecs[i].val);
            chk($sformatf("busy_start[%0d]", i), 32'(o_busy), 32'h1);
            chk($sformatf("vld_start[%0d]", i), 32'(o_val_vld), 32'h0);
            wait_upd(lat, vld_ok);
            chk($sformatf("latency[%0d]", i), lat, exp_lat);
            chk($sformatf("val[%0d]", i), 32'(o_val), 32'(vecs[i].exp_val));
            chk($sformatf("zero[%0d]", i), 32'(o_zero), 32'(vecs[i].exp_zero));
            chk($sformatf("vld_upd[%0d]", i), 32'(o_val_vld), 32'h1);
            chk($sformatf("vld_low_wait[%0d]", i), 32'(vld_ok), 32'h1);
            chk($sformatf("busy_upd[%0d]", i), 32'(o_busy), 32'h0);
            tick();
            chk($sformatf("upd_one_cycle[%0d]", i), 32'(o_val_upd), 32'h0);
            chk($sformatf("val_hold[%0d]", i), 32'(o_val), 32'(vecs[i].exp_val));
            tick();
        end

        // Restart three edges after the first start: only the second operand reports.
        start_op(16'h8000);
        pulses = 0;
        vld_ok = 1'b1;
        repeat (2) begin
            tick();
            if (o_val_upd) pulses++;
            if (o_val_vld) vld_ok = 1'b0;
        end
        start_op(16'd4);
        first_val = 8'hXX;
        for (int c = 0; c < 40; c++) begin
            if (o_val_upd) begin
                if (pulses == 0) first_val = o_val;
                pulses++;
            end
            if (pulses == 0 && o_val_vld) vld_ok = 1'b0;
            tick();
        end
        chk("abort_pulses", pulses, 1);
        chk("abort_val", 32'(first_val), 32'h20);
        chk("abort_vld_low", 32'(vld_ok), 32'h1);
        chk("abort_vld_end", 32'(o_val_vld), 32'h1);

        // Reset in the middle of FRAC for operand 3.
        start_op(16'd3);
        repeat (4) tick();
        chk("pre_rst_busy", 32'(o_busy), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_val",  32'(o_val), 32'h0);
        chk("midrst_vld",  32'(o_val_vld), 32'h0);
        chk("midrst_upd",  32'(o_val_upd), 32'h0);
        chk("midrst_zero", 32'(o_zero), 32'h0);
        chk("midrst_busy", 32'(o_busy), 32'h0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_val_upd) pulses++;
        end
        chk("midrst_no_upd", pulses, 0);

        // Start coinciding with reset: reset wins.
        rst_n     = 1'b0;
        i_val     = 16'd7;
        i_cal_str = 1'b1;
        tick();
        i_cal_str = 1'b0;
        rst_n     = 1'b1;
        chk("strrst_busy", 32'(o_busy), 32'h0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_val_upd) pulses++;
        end
        chk("strrst_no_upd", pulses, 0);

        // Operation resumes normally afterwards.
        start_op(16'd2);
        wait_upd(lat, vld_ok);
        chk("post_latency", lat, 2 + NFR);
        chk("post_val", 32'(o_val), 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
